// File: rtl/packet_event_indicator_pkg.sv
// Shared encodings for the packet event indicator:
// LED mode codes and the per-channel hold state.
package packet_event_indicator_pkg;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RETRIG  = 2'b01;
   localparam logic [1:0] MODE_BLINK   = 2'b10;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } ch_state_e;

endpackage

// File: rtl/packet_event_indicator_stretch.sv
// One event channel: edge detect, hold FSM, blink phase
// and a saturating event counter.
module event_stretch_ch
   import packet_event_indicator_pkg::*;
#(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int TIMER_W     = 25,
   parameter int BLINK_HALF  = 2_000_000,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             event_i,
   input  logic [1:0]       mode_i,
   input  logic             clr_i,
   output logic             active_o,
   output logic             led_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ch_state_e state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [TIMER_W-1:0] bcnt_q, bcnt_d;
   logic phase_q, phase_d;
   logic led_q, led_d;
   logic prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic sat_q, sat_d;

   logic acc, retrig, term;

   assign acc    = event_i & ~prev_q & en_i;
   assign retrig = acc & ((mode_i == MODE_RETRIG) |
                          (mode_i == MODE_BLINK));
   assign term   = (timer_q == TIMER_W'(HOLD_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         timer_q <= '0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
         led_q   <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         led_q   <= led_d;
         prev_q  <= event_i;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   // A retrigger on the terminal cycle takes priority over expiry.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               state_d = HOLD;
               timer_d = '0;
               bcnt_d  = '0;
               phase_d = 1'b1;
            end
         end
         HOLD: begin
            if (retrig) begin
               timer_d = '0;
               bcnt_d  = '0;
               phase_d = 1'b1;
            end else if (term) begin
               state_d = IDLE;
               timer_d = '0;
               bcnt_d  = '0;
               phase_d = 1'b0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
               if (bcnt_q == TIMER_W'(BLINK_HALF - 1)) begin
                  bcnt_d  = '0;
                  phase_d = ~phase_q;
               end else begin
                  bcnt_d = bcnt_q + TIMER_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      led_d = (state_d == HOLD) &&
              ((mode_i != MODE_BLINK) || phase_d);
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr_i) begin
         cnt_d = CNT_W'(acc);
         sat_d = 1'b0;
      end else if (acc) begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         sat_d = sat_q | (cnt_d == CNT_MAX);
      end
   end

   assign active_o = (state_q == HOLD);
   assign led_o    = led_q;
   assign cnt_o    = cnt_q;
   assign sat_o    = sat_q;

endmodule

// File: rtl/packet_event_indicator.sv
// Multi-channel LED stretcher for receiver events with
// per-channel counters and a registered readout mux.
module packet_event_indicator
   import packet_event_indicator_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int TIMER_W     = 25,
   parameter int BLINK_HALF  = 2_000_000,
   parameter int CNT_W       = 16,
   localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_CH-1:0]  event_in,
   input  logic [1:0]       mode,
   input  logic [SEL_W-1:0] rd_sel,
   input  logic             cnt_clr,
   output logic [N_CH-1:0]  led_out,
   output logic [N_CH-1:0]  active,
   output logic             any_active,
   output logic [CNT_W-1:0] count_out,
   output logic             count_sat
);

   logic [CNT_W-1:0] cnt_w [N_CH];
   logic [N_CH-1:0]  sat_w;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sat_q, sat_d;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      event_stretch_ch #(
         .HOLD_CYCLES (HOLD_CYCLES),
         .TIMER_W     (TIMER_W),
         .BLINK_HALF  (BLINK_HALF),
         .CNT_W       (CNT_W)
      ) u_ch (
         .clk_i    (clk),
         .rst_i    (rst),
         .en_i     (en),
         .event_i  (event_in[g]),
         .mode_i   (mode),
         .clr_i    (cnt_clr && (rd_sel == SEL_W'(g))),
         .active_o (active[g]),
         .led_o    (led_out[g]),
         .cnt_o    (cnt_w[g]),
         .sat_o    (sat_w[g])
      );
   end

   // Selects with no matching channel read back as zero.
   always_comb begin
      count_d = '0;
      sat_d   = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            count_d = cnt_w[i];
            sat_d   = sat_w[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end

   assign count_out  = count_q;
   assign count_sat  = sat_q;
   assign any_active = |active;

endmodule

// File: tb/tb_packet_event_indicator.sv
// Scenario bench for packet_event_indicator against a
// cycle-count reference model of hold, blink and counters.
module tb_packet_event_indicator;

   localparam int N  = 4;
   localparam int HC = 10;
   localparam int BH = 3;
   localparam int CW = 4;
   localparam int TW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic [N-1:0] event_in;
   logic [1:0] mode;
   logic [1:0] rd_sel;
   logic cnt_clr;
   logic [N-1:0] led_out;
   logic [N-1:0] active;
   logic any_active;
   logic [CW-1:0] count_out;
   logic count_sat;

   int total = 0;
   int bad = 0;

   int hold_left [N];
   int since [N];
   int cnt [N];
   bit sat [N];
   bit prev [N];
   logic [N-1:0] exp_active = '0;
   logic [N-1:0] exp_led = '0;
   logic [CW-1:0] exp_cout = '0;
   logic exp_csat = 1'b0;

   packet_event_indicator #(
      .N_CH        (N),
      .HOLD_CYCLES (HC),
      .TIMER_W     (TW),
      .BLINK_HALF  (BH),
      .CNT_W       (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .event_in   (event_in),
      .mode       (mode),
      .rd_sel     (rd_sel),
      .cnt_clr    (cnt_clr),
      .led_out    (led_out),
      .active     (active),
      .any_active (any_active),
      .count_out  (count_out),
      .count_sat  (count_sat)
   );

   always #5 clk = ~clk;

   // Model: a hold lasts HC cycles counted down from the
   // last (re)start; blink phase is (cycles since start / BH) even.
   task automatic mdl_edge();
      bit acc;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            hold_left[i] = 0; since[i] = 0; cnt[i] = 0;
            sat[i] = 0; prev[i] = 0;
         end
         exp_active = '0; exp_led = '0;
         exp_cout = '0; exp_csat = 1'b0;
         return;
      end
      exp_cout = CW'(cnt[rd_sel]);
      exp_csat = sat[rd_sel];
      for (int i = 0; i < N; i++) begin
         acc = event_in[i] && !prev[i] && en;
         prev[i] = event_in[i];
         if (hold_left[i] == 0) begin
            if (acc) begin hold_left[i] = HC; since[i] = 0; end
         end else if (acc && (mode == 2'b01 || mode == 2'b10)) begin
            hold_left[i] = HC; since[i] = 0;
         end else begin
            hold_left[i]--; since[i]++;
         end
         if (cnt_clr && rd_sel == i) begin
            cnt[i] = acc ? 1 : 0; sat[i] = 0;
         end else if (acc) begin
            if (cnt[i] < CMAX) cnt[i]++;
            if (cnt[i] == CMAX) sat[i] = 1;
         end
         exp_active[i] = hold_left[i] > 0;
         exp_led[i] = exp_active[i] &&
                      (mode != 2'b10 || ((since[i] / BH) % 2) == 0);
      end
   endtask

   task automatic tick();
      mdl_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic test_reset();
      rst = 1; en = 1; event_in = '0; mode = 2'b00;
      rd_sel = '0; cnt_clr = 0;
      tick(); tick();
      rst = 0;
      total++;
      if ({led_out, active, any_active, count_out, count_sat} !== '0) begin
         bad++;
         $display("FAIL reset_outs got=%b/%b/%b/%h/%b req=all zero",
                  led_out, active, any_active, count_out, count_sat);
      end
      tick();
      total++;
      if ({led_out, active, any_active, count_out, count_sat} !== '0) begin
         bad++;
         $display("FAIL reset_idle got=%b/%b/%b/%h/%b req=all zero",
                  led_out, active, any_active, count_out, count_sat);
      end
   endtask

   task automatic test_oneshot();
      int hi = 0;
      mode = 2'b00; rd_sel = 2'd0;
      event_in = 4'b0001; tick(); event_in = '0;
      for (int c = 1; c <= 14; c++) begin
         total++;
         if (active !== exp_active || led_out !== exp_led ||
             any_active !== |exp_active) begin
            bad++;
            $display("FAIL oneshot_cyc c=%0d act=%b led=%b req=%b/%b",
                     c, active, led_out, exp_active, exp_led);
         end
         if (active[0]) hi++;
         event_in = (c == 5) ? 4'b0001 : 4'b0000;
         tick();
      end
      event_in = '0;
      total++;
      if (hi != HC) begin
         bad++;
         $display("FAIL oneshot_len got=%0d req=%0d", hi, HC);
      end
      tick();
      total++;
      if (count_out !== CW'(2) || count_out !== exp_cout) begin
         bad++;
         $display("FAIL oneshot_count got=%0d req=2 (model %0d)",
                  count_out, exp_cout);
      end
   endtask

   task automatic test_retrigger();
      int hi = 0;
      bit gap = 0;
      mode = 2'b01; rd_sel = 2'd1;
      event_in = 4'b0010; tick(); event_in = '0;
      for (int c = 1; c <= 24; c++) begin
         total++;
         if (active !== exp_active || led_out !== exp_led) begin
            bad++;
            $display("FAIL retrig_cyc c=%0d act=%b led=%b req=%b/%b",
                     c, active, led_out, exp_active, exp_led);
         end
         if (active[1]) begin
            hi++;
            if (hi != c) gap = 1;
         end
         event_in = (c == HC) ? 4'b0010 : 4'b0000;
         tick();
      end
      total++;
      if (hi != 2 * HC || gap) begin
         bad++;
         $display("FAIL retrig_len got=%0d gap=%0d req=%0d gap=0",
                  hi, gap, 2 * HC);
      end
      event_in = 4'b0010;
      for (int c = 0; c < 25; c++) tick();
      total++;
      if (active[1] !== 1'b0 || active !== exp_active) begin
         bad++;
         $display("FAIL stuck_high act=%b req=%b", active, exp_active);
      end
      event_in = '0;
      tick();
      total++;
      if (count_out !== exp_cout || count_out !== CW'(3)) begin
         bad++;
         $display("FAIL stuck_count got=%0d req=3", count_out);
      end
   endtask

   task automatic test_blink();
      int pat [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0};
      mode = 2'b10;
      idle(12);
      event_in = 4'b0100; tick(); event_in = '0;
      for (int c = 1; c <= 11; c++) begin
         total++;
         if (led_out[2] !== pat[c-1][0] || active[2] !== (c <= HC) ||
             led_out !== exp_led) begin
            bad++;
            $display("FAIL blink_pat c=%0d led=%b act=%b req=%0d/%0d",
                     c, led_out[2], active[2], pat[c-1], c <= HC);
         end
         tick();
      end
      event_in = 4'b0100; tick(); event_in = '0;
      idle(3);
      mode = 2'b00;
      tick();
      total++;
      if (led_out[2] !== 1'b1 || led_out !== active || led_out !== exp_led) begin
         bad++;
         $display("FAIL blink_exit led=%b act=%b req=%b",
                  led_out, active, exp_led);
      end
      idle(8);
   endtask

   task automatic test_counter();
      mode = 2'b00; rd_sel = 2'd3;
      for (int p = 0; p < 16; p++) begin
         event_in = 4'b1000; tick();
         event_in = '0; tick();
      end
      tick();
      total++;
      if (count_out !== CW'(15) || count_sat !== 1'b1) begin
         bad++;
         $display("FAIL cnt_sat got=%0d/%b req=15/1", count_out, count_sat);
      end
      cnt_clr = 1; event_in = 4'b1000; tick();
      cnt_clr = 0; event_in = '0;
      total++;
      if (count_out !== CW'(15) || count_sat !== 1'b1) begin
         bad++;
         $display("FAIL cnt_clr_lat got=%0d/%b req=15/1",
                  count_out, count_sat);
      end
      tick();
      total++;
      if (count_out !== CW'(1) || count_sat !== 1'b0 ||
          count_out !== exp_cout) begin
         bad++;
         $display("FAIL cnt_clr_pulse got=%0d/%b req=1/0",
                  count_out, count_sat);
      end
   endtask

   task automatic test_enable();
      int hi = 0;
      idle(12);
      en = 0; event_in = 4'b1111; tick(); event_in = '0;
      idle(3);
      total++;
      if (active !== 4'b0000 || count_out !== CW'(1) ||
          active !== exp_active) begin
         bad++;
         $display("FAIL en_block act=%b cnt=%0d req=0000/1",
                  active, count_out);
      end
      en = 1; event_in = 4'b0001; tick();
      en = 0; event_in = '0;
      for (int c = 1; c <= 12; c++) begin
         if (active[0]) hi++;
         tick();
      end
      total++;
      if (hi != HC || active !== exp_active) begin
         bad++;
         $display("FAIL en_fall_hold got=%0d req=%0d", hi, HC);
      end
      en = 1;
   endtask

   task automatic test_reset_mid();
      event_in = 4'b1111; tick(); event_in = '0;
      idle(3);
      rst = 1; event_in = 4'b1111; tick();
      total++;
      if ({led_out, active, any_active, count_out, count_sat} !== '0) begin
         bad++;
         $display("FAIL rst_mid got=%b/%b/%b req=0", led_out, active,
                  count_out);
      end
      tick();
      rst = 0; tick();
      total++;
      if (active !== 4'b1111 || active !== exp_active) begin
         bad++;
         $display("FAIL rst_release act=%b req=1111", active);
      end
      idle(14);
      total++;
      if (active !== 4'b0000) begin
         bad++;
         $display("FAIL rst_one_pulse act=%b req=0000", active);
      end
      event_in = '0;
      for (int i = 0; i < N; i++) begin
         rd_sel = 2'(i); tick();
         total++;
         if (count_out !== CW'(1) || count_out !== exp_cout) begin
            bad++;
            $display("FAIL rst_cnt ch=%0d got=%0d req=1", i, count_out);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         en = ($urandom_range(0, 3) != 0);
         event_in = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
         rd_sel = 2'($urandom);
         cnt_clr = ($urandom_range(0, 15) == 0);
         tick();
         total++;
         if (active !== exp_active || led_out !== exp_led ||
             any_active !== |exp_active || count_out !== exp_cout ||
             count_sat !== exp_csat) begin
            bad++;
            $display("FAIL random c=%0d got=%b/%b/%0d/%b req=%b/%b/%0d/%b",
                     c, active, led_out, count_out, count_sat,
                     exp_active, exp_led, exp_cout, exp_csat);
         end
      end
      rst = 0; cnt_clr = 0;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_retrigger();
      test_blink();
      test_counter();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
